morse_uart_tx: RTL
==================

Name: morse_uart_tx

Overview:
- Downstream stage of the Morse reader. It consumes each decoded ASCII character produced by the Morse-to-ASCII conversion and buffers it in a small FIFO.
- It serialises each buffered character onto a UART 8N1 line for a host terminal.
- It decouples the user's letter rate from the serial bit rate and reports overflow when the user outruns the link.

Parameters:
- CLKS_PER_BIT, 5208: clock cycles per UART bit (50 MHz / 9600 baud). Legal range 2 to 65535.
- FIFO_DEPTH, 8: character FIFO entries. Must be a power of two, 2 to 64.
- FIFO_AW, 3: FIFO address width, equal to log2(FIFO_DEPTH).

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- char_in, input, 8: ASCII character from the decoder.
- char_valid, input, 1: char_in is valid this cycle.
- char_ready, output, 1: FIFO can accept a character; equals !full.
- tx, output, 1: UART serial output; idles high.
- busy, output, 1: high while a frame is being shifted (FSM not in IDLE).
- fifo_count, output, FIFO_AW+1: number of characters held in the FIFO. Excludes the character in the shift register.
- overflow, output, 1: one-cycle pulse when char_valid is high while full; that character is dropped.

Behaviour:
- Reset (async assert, sync release):
  - tx=1, busy=0, fifo_count=0, char_ready=1, overflow=0.
  - FIFO pointers are cleared and the FSM goes to IDLE.
  - Reset mid-frame aborts the frame: tx returns to 1 on assertion, with no partial stop bit.
- Write:
  - A character is accepted when char_valid && char_ready.
  - It is stored at the write pointer, and fifo_count increments on the next edge.
  - When full, the write is refused and overflow pulses in the same cycle (registered output, visible the next cycle).
  - Pointers wrap modulo FIFO_DEPTH. fifo_count is (FIFO_AW+1) bits wide, so count==FIFO_DEPTH is distinguishable from 0.
- Simultaneous push and pop:
  - When not full, both take effect and fifo_count is unchanged.
  - A push while full is refused even if a pop happens in that cycle, because ready is based on the registered count.
- FSM states:
  - IDLE: if fifo_count!=0, pop the head into the 8-bit shift register, clear the baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Shift right every CLKS_PER_BIT cycles. After bit 7, go to STOP (or PARITY, see the optional feature).
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Latency:
  - Character accepted at cycle N into an empty FIFO with the FSM idle: fifo_count=1 at N+1, pop at N+1, tx falls at N+2.
  - A frame is 10 × CLKS_PER_BIT cycles.
  - Back-to-back frames have exactly one IDLE cycle between the end of STOP and the next START.
- Baud counter: counts 0 to CLKS_PER_BIT-1, 16 bits wide. A bit period ends on terminal count.
- tx is registered, so there are no glitches.
- char_in is ignored when char_valid=0. Any 8-bit value, including 0x00, is transmitted unchanged.

Optional Feature:
- Macro: MORSE_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - The frame becomes 11 × CLKS_PER_BIT cycles (8E1).
- When undefined: there is no PARITY state and no parity logic, and the frame is 8N1.

Decomposition:
- Package morse_uart_pkg holds:
  - FSM state encodings: IDLE, START, DATA, PARITY, STOP, as 3-bit localparams.
  - Constants UART_IDLE_LEVEL=1, START_LEVEL=0, DATA_BITS=8.
  - The default CLKS_PER_BIT.
- Sub-module morse_char_fifo:
  - Synchronous FIFO parameterised by width and depth.
  - Ports: push, pop, din, dout, full, empty, count.
  - morse_uart_tx instantiates it and holds the baud counter and the FSM.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=8):
1. Reset, then push 'A' (0x41) at cycle 0:
   - tx falls at cycle 2.
   - Bit sequence 0,1,0,0,0,0,0,1,0,1, each held 4 cycles.
   - busy is high for 40 cycles, then low; fifo_count returns to 0.
2. Push 10 characters on consecutive cycles 0–9:
   - Characters at cycles 0–8 are accepted; char_ready goes low at cycle 9.
   - The 10th character produces one overflow pulse.
   - The serial output is the first 9 characters in order.
3. Push 'E' then 'T' on consecutive cycles:
   - Two frames are sent with exactly one idle-high cycle between the STOP of 'E' and the START of 'T'.
4. Assert rst 15 cycles into a frame of 'S' (0x53):
   - tx=1 immediately; busy=0 and fifo_count=0.
   - After release, no remnant of 'S' is transmitted; a new push of 'O' transmits a clean frame.
5. With the FIFO full and a frame in progress, hold char_valid high:
   - At the IDLE pop, char_ready rises for exactly one cycle and one character is accepted.
   - overflow pulses on every other cycle in which char_valid is high while full.
6. With MORSE_TX_PARITY_EN defined, push 0x07:
   - Parity bit = 1; frame = 0, 1,1,1,0,0,0,0,0, 1, 1; 44 cycles total.

Source files
------------

// File: rtl/morse_uart_pkg.sv
// Shared definitions for the Morse reader UART transmit stage.
// Holds the transmit FSM state encodings, line-level constants and the
// default bit period. Build macro: MORSE_TX_PARITY_EN (adds an even-parity
// bit, turning the 8N1 frame into 8E1).
package morse_uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } tx_state_e;

  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam logic START_LEVEL     = 1'b0;
  localparam int   DATA_BITS       = 8;

  // 50 MHz system clock, 9600 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 5208;

endpackage

// File: rtl/morse_char_fifo.sv
// Synchronous character FIFO with show-ahead read data.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push_i        write request (ignored while full)
//   pop_i         read request (ignored while empty)
//   din_i         write data
//   dout_o        head entry, valid whenever empty_o is low
//   full_o        count == DEPTH
//   empty_o       count == 0
//   count_o       entries held, AW+1 bits so DEPTH is distinguishable from 0
module morse_char_fifo
  import morse_uart_pkg::*;
#(
  parameter int WIDTH = DATA_BITS,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/morse_uart_tx.sv
// Buffers decoded ASCII characters and serialises them as UART frames
// (8N1, or 8E1 when MORSE_TX_PARITY_EN is defined).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   char_in       character from the Morse decoder
//   char_valid    char_in valid this cycle
//   char_ready    FIFO can take a character (not full)
//   tx            registered serial line, idles high
//   busy          a frame is being shifted out
//   fifo_count    characters waiting in the FIFO (not the one shifting)
//   overflow      one-cycle pulse: a character arrived while full and was dropped
//   dbg_state     current transmit FSM state
// Handshake: a character transfers on a rising edge where char_valid and
// char_ready are both high; char_ready depends only on registered state,
// so a pop in the same cycle never turns a full-FIFO write into an accept.
module morse_uart_tx
  import morse_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 8,
  parameter int FIFO_AW      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         char_in,
  input  logic               char_valid,
  output logic               char_ready,
  output logic               tx,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow,
  output logic [2:0]         dbg_state
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);

  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        overflow_q;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        baud_done;
`ifdef MORSE_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  morse_char_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (char_valid),
    .pop_i   (pop),
    .din_i   (char_in),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign char_ready = !fifo_full;
  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);
  assign overflow   = overflow_q;
  assign dbg_state  = state_q;
  assign baud_done  = (baud_q == BAUD_LAST);

  // tx_d is the line level for the state being entered, so the registered
  // line changes on the same edge as the state.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
`ifdef MORSE_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = UART_IDLE_LEVEL;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          baud_d  = '0;
          state_d = START;
          tx_d    = START_LEVEL;
`ifdef MORSE_TX_PARITY_EN
          parity_d = ^fifo_dout;
`endif
        end
      end
      START: begin
        baud_d = baud_q + 16'd1;
        if (baud_done) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = DATA;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        baud_d = baud_q + 16'd1;
        if (baud_done) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_idx_q == BIT_LAST) begin
`ifdef MORSE_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = UART_IDLE_LEVEL;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end
      end
`ifdef MORSE_TX_PARITY_EN
      PARITY: begin
        baud_d = baud_q + 16'd1;
        if (baud_done) begin
          baud_d  = '0;
          state_d = STOP;
          tx_d    = UART_IDLE_LEVEL;
        end
      end
`endif
      STOP: begin
        baud_d = baud_q + 16'd1;
        if (baud_done) begin
          baud_d  = '0;
          state_d = IDLE;
          tx_d    = UART_IDLE_LEVEL;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = UART_IDLE_LEVEL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= UART_IDLE_LEVEL;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= char_valid && fifo_full;
    end
  end

`ifdef MORSE_TX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_q <= 1'b0;
    else     parity_q <= parity_d;
  end
`endif

endmodule
